// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side bundle for alu_arbiter.
// The slave modport is the arbiter's view; master is the requesters/ALU side.
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int CNT_W  = 16
);
    logic              i_req0_valid;
    logic              o_req0_ready;
    logic [OP_W-1:0]   i_req0_op;
    logic [DATA_W-1:0] i_req0_a;
    logic [DATA_W-1:0] i_req0_b;
    logic              o_rsp0_valid;
    logic              i_rsp0_ready;
    logic [DATA_W-1:0] o_rsp0_data;
    logic              o_rsp0_zero;
    logic              o_rsp0_err;
    logic [CNT_W-1:0]  o_gnt0_cnt;

    logic              i_req1_valid;
    logic              o_req1_ready;
    logic [OP_W-1:0]   i_req1_op;
    logic [DATA_W-1:0] i_req1_a;
    logic [DATA_W-1:0] i_req1_b;
    logic              o_rsp1_valid;
    logic              i_rsp1_ready;
    logic [DATA_W-1:0] o_rsp1_data;
    logic              o_rsp1_zero;
    logic              o_rsp1_err;
    logic [CNT_W-1:0]  o_gnt1_cnt;

    logic [DATA_W-1:0] o_alu_operand_a;
    logic [DATA_W-1:0] o_alu_operand_b;
    logic [OP_W-1:0]   o_alu_op;
    logic [DATA_W-1:0] i_alu_data;
    logic              i_alu_zero;

    modport slave (
        input  i_req0_valid, i_req0_op, i_req0_a, i_req0_b, i_rsp0_ready,
        input  i_req1_valid, i_req1_op, i_req1_a, i_req1_b, i_rsp1_ready,
        input  i_alu_data, i_alu_zero,
        output o_req0_ready, o_rsp0_valid, o_rsp0_data, o_rsp0_zero, o_rsp0_err, o_gnt0_cnt,
        output o_req1_ready, o_rsp1_valid, o_rsp1_data, o_rsp1_zero, o_rsp1_err, o_gnt1_cnt,
        output o_alu_operand_a, o_alu_operand_b, o_alu_op
    );

    modport master (
        output i_req0_valid, i_req0_op, i_req0_a, i_req0_b, i_rsp0_ready,
        output i_req1_valid, i_req1_op, i_req1_a, i_req1_b, i_rsp1_ready,
        output i_alu_data, i_alu_zero,
        input  o_req0_ready, o_rsp0_valid, o_rsp0_data, o_rsp0_zero, o_rsp0_err, o_gnt0_cnt,
        input  o_req1_ready, o_rsp1_valid, o_rsp1_data, o_rsp1_zero, o_rsp1_err, o_gnt1_cnt,
        input  o_alu_operand_a, o_alu_operand_b, o_alu_op
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared single-cycle ALU.
// Each requester owns a one-entry response slot loaded one cycle after its
// grant; illegal opcodes still consume a grant but return err=1 and data=0.
module alu_arbiter #(
    parameter int          DATA_W  = 32,
    parameter int          OP_W    = 4,
    parameter int unsigned NUM_OPS = 10,
    parameter int          CNT_W   = 16
) (
    input logic         i_clk,
    input logic         i_rst,
    alu_arbiter_if.slave bus
);

    logic              r_last;
    logic              r_rsp0_valid;
    logic [DATA_W-1:0] r_rsp0_data;
    logic              r_rsp0_zero;
    logic              r_rsp0_err;
    logic              r_rsp1_valid;
    logic [DATA_W-1:0] r_rsp1_data;
    logic              r_rsp1_zero;
    logic              r_rsp1_err;
    logic [CNT_W-1:0]  r_gnt0_cnt;
    logic [CNT_W-1:0]  r_gnt1_cnt;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic [OP_W-1:0]   w_sel_op;
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;
    logic              w_sel_legal;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // A full slot only blocks a requester if it is not being popped this cycle.
    assign w_elig0 = bus.i_req0_valid && (!r_rsp0_valid || bus.i_rsp0_ready);
    assign w_elig1 = bus.i_req1_valid && (!r_rsp1_valid || bus.i_rsp1_ready);

    // r_last names the requester granted most recently; the other wins a tie.
    assign w_gnt0 = !i_rst && w_elig0 && (!w_elig1 || r_last);
    assign w_gnt1 = !i_rst && w_elig1 && (!w_elig0 || !r_last);

    // Select the winning request's payload (req0 is a don't-care default).
    always_comb begin
        w_sel_op = bus.i_req0_op;
        w_sel_a  = bus.i_req0_a;
        w_sel_b  = bus.i_req0_b;
        if (w_gnt1) begin
            w_sel_op = bus.i_req1_op;
            w_sel_a  = bus.i_req1_a;
            w_sel_b  = bus.i_req1_b;
        end
    end

    assign w_sel_legal = (32'(w_sel_op) < NUM_OPS);

    // Drive the ALU only for a legal granted op; otherwise hold it at add 0,0.
    always_comb begin
        bus.o_alu_op        = '0;
        bus.o_alu_operand_a = '0;
        bus.o_alu_operand_b = '0;
        if ((w_gnt0 || w_gnt1) && w_sel_legal) begin
            bus.o_alu_op        = w_sel_op;
            bus.o_alu_operand_a = w_sel_a;
            bus.o_alu_operand_b = w_sel_b;
        end
    end

    // Requester 0 response slot: load on grant, clear on pop without reload.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp0_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp0_zero  <= 1'b0;
            r_rsp0_err   <= 1'b0;
        end else if (w_gnt0) begin
            r_rsp0_valid <= 1'b1;
            r_rsp0_data  <= w_sel_legal ? bus.i_alu_data : '0;
            r_rsp0_zero  <= w_sel_legal && bus.i_alu_zero;
            r_rsp0_err   <= !w_sel_legal;
        end else if (bus.i_rsp0_ready) begin
            r_rsp0_valid <= 1'b0;
        end
    end

    // Requester 1 response slot: load on grant, clear on pop without reload.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp1_valid <= 1'b0;
            r_rsp1_data  <= '0;
            r_rsp1_zero  <= 1'b0;
            r_rsp1_err   <= 1'b0;
        end else if (w_gnt1) begin
            r_rsp1_valid <= 1'b1;
            r_rsp1_data  <= w_sel_legal ? bus.i_alu_data : '0;
            r_rsp1_zero  <= w_sel_legal && bus.i_alu_zero;
            r_rsp1_err   <= !w_sel_legal;
        end else if (bus.i_rsp1_ready) begin
            r_rsp1_valid <= 1'b0;
        end
    end

    // Round-robin pointer and saturating grant counters; both move only on a grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last     <= 1'b1;
            r_gnt0_cnt <= '0;
            r_gnt1_cnt <= '0;
        end else begin
            if (w_gnt0) begin
                r_last     <= 1'b0;
                r_gnt0_cnt <= sat_inc(r_gnt0_cnt);
            end
            if (w_gnt1) begin
                r_last     <= 1'b1;
                r_gnt1_cnt <= sat_inc(r_gnt1_cnt);
            end
        end
    end

    assign bus.o_req0_ready = w_gnt0;
    assign bus.o_req1_ready = w_gnt1;
    assign bus.o_rsp0_valid = r_rsp0_valid;
    assign bus.o_rsp0_data  = r_rsp0_data;
    assign bus.o_rsp0_zero  = r_rsp0_zero;
    assign bus.o_rsp0_err   = r_rsp0_err;
    assign bus.o_rsp1_valid = r_rsp1_valid;
    assign bus.o_rsp1_data  = r_rsp1_data;
    assign bus.o_rsp1_zero  = r_rsp1_zero;
    assign bus.o_rsp1_err   = r_rsp1_err;
    assign bus.o_gnt0_cnt   = r_gnt0_cnt;
    assign bus.o_gnt1_cnt   = r_gnt1_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: golden ALU on the ALU port, a rule-level model of
// grants/slots/counters checked every negedge, plus directed literal checks.
module tb_alu_arbiter;

    localparam int DW   = 32;
    localparam int OW   = 4;
    localparam int CW   = 4;
    localparam int NOPS = 10;

    logic i_clk = 1'b0;
    logic rst;
    always #5 i_clk = ~i_clk;

    alu_arbiter_if #(.DATA_W(DW), .OP_W(OW), .CNT_W(CW)) bus ();

    alu_arbiter #(.DATA_W(DW), .OP_W(OW), .NUM_OPS(NOPS), .CNT_W(CW)) dut (
        .i_clk (i_clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return {31'd0, a < b};
            4'd8: return {31'd0, $signed(a) < $signed(b)};
            4'd9: return $unsigned($signed(a) >>> b[4:0]);
            default: return '0;
        endcase
    endfunction

    // External ALU stand-in
    always_comb begin
        bus.i_alu_data = alu_f(bus.o_alu_op, bus.o_alu_operand_a, bus.o_alu_operand_b);
        bus.i_alu_zero = (bus.i_alu_data == '0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic          m_vld [2] = '{1'b0, 1'b0};
    logic [DW-1:0] m_data[2] = '{32'd0, 32'd0};
    logic          m_zero[2] = '{1'b0, 1'b0};
    logic          m_err [2] = '{1'b0, 1'b0};
    int            m_cnt [2] = '{0, 0};
    int            m_last    = 1;

    always @(negedge i_clk) begin
        if (chk_en) begin
            logic          v[2], rr[2], el[2], lg;
            logic [OW-1:0] op[2];
            logic [DW-1:0] a[2], b[2];
            logic [DW-1:0] res;
            int            win;
            v[0] = bus.i_req0_valid; rr[0] = bus.i_rsp0_ready; op[0] = bus.i_req0_op;
            a[0] = bus.i_req0_a;     b[0]  = bus.i_req0_b;
            v[1] = bus.i_req1_valid; rr[1] = bus.i_rsp1_ready; op[1] = bus.i_req1_op;
            a[1] = bus.i_req1_a;     b[1]  = bus.i_req1_b;
            for (int k = 0; k < 2; k++) el[k] = v[k] && (!m_vld[k] || rr[k]);
            win = -1;
            if (!rst) begin
                if (el[0] && el[1]) win = 1 - m_last;
                else if (el[0])     win = 0;
                else if (el[1])     win = 1;
            end
            lg = (win >= 0) ? (int'(op[win]) < NOPS) : 1'b0;

            check("m_ready0", bus.o_req0_ready, win == 0);
            check("m_ready1", bus.o_req1_ready, win == 1);
            check("m_alu_op", bus.o_alu_op, lg ? op[win] : 4'd0);
            check("m_alu_a",  bus.o_alu_operand_a, lg ? a[win] : 32'd0);
            check("m_alu_b",  bus.o_alu_operand_b, lg ? b[win] : 32'd0);
            check("m_rsp0_valid", bus.o_rsp0_valid, m_vld[0]);
            check("m_rsp1_valid", bus.o_rsp1_valid, m_vld[1]);
            check("m_cnt0", bus.o_gnt0_cnt, m_cnt[0]);
            check("m_cnt1", bus.o_gnt1_cnt, m_cnt[1]);
            if (m_vld[0]) begin
                check("m_rsp0_data", bus.o_rsp0_data, m_data[0]);
                check("m_rsp0_zero", bus.o_rsp0_zero, m_zero[0]);
                check("m_rsp0_err",  bus.o_rsp0_err,  m_err[0]);
            end
            if (m_vld[1]) begin
                check("m_rsp1_data", bus.o_rsp1_data, m_data[1]);
                check("m_rsp1_zero", bus.o_rsp1_zero, m_zero[1]);
                check("m_rsp1_err",  bus.o_rsp1_err,  m_err[1]);
            end

            // state after the coming posedge
            if (rst) begin
                for (int k = 0; k < 2; k++) begin
                    m_vld[k] = 1'b0; m_data[k] = '0; m_zero[k] = 1'b0;
                    m_err[k] = 1'b0; m_cnt[k] = 0;
                end
                m_last = 1;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (win == k) begin
                        res       = lg ? alu_f(op[k], a[k], b[k]) : '0;
                        m_vld[k]  = 1'b1;
                        m_data[k] = res;
                        m_zero[k] = lg && (res == '0);
                        m_err[k]  = !lg;
                        m_cnt[k]  = (m_cnt[k] >= (1 << CW) - 1) ? m_cnt[k] : m_cnt[k] + 1;
                        m_last    = k;
                    end else if (rr[k]) begin
                        m_vld[k] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge i_clk);
        #2;
    endtask

    initial begin
        logic g0;
        int   o0, o1;
        rst = 1'b1;
        bus.i_req0_valid = 1'b1; bus.i_req0_op = 4'd0; bus.i_req0_a = 32'd1; bus.i_req0_b = 32'd1;
        bus.i_req1_valid = 1'b1; bus.i_req1_op = 4'd0; bus.i_req1_a = 32'd2; bus.i_req1_b = 32'd2;
        bus.i_rsp0_ready = 1'b1; bus.i_rsp1_ready = 1'b1;

        // reset held two cycles with both requests valid
        cyc();
        chk_en = 1'b1;
        #1;
        check("rst_ready0", bus.o_req0_ready, 1'b0);
        check("rst_ready1", bus.o_req1_ready, 1'b0);
        cyc();
        check("rst_rsp0_valid", bus.o_rsp0_valid, 1'b0);
        check("rst_rsp1_valid", bus.o_rsp1_valid, 1'b0);
        check("rst_cnt0", bus.o_gnt0_cnt, 4'd0);
        check("rst_cnt1", bus.o_gnt1_cnt, 4'd0);

        // release: requester 0 wins the first contention
        rst = 1'b0;
        #1;
        check("first_ready0", bus.o_req0_ready, 1'b1);
        check("first_ready1", bus.o_req1_ready, 1'b0);
        cyc();

        // single op: add 5+7, then sub equal values
        bus.i_req1_valid = 1'b0;
        bus.i_req0_op = 4'd0; bus.i_req0_a = 32'd5; bus.i_req0_b = 32'd7;
        #1;
        check("add_alu_op", bus.o_alu_op, 4'd0);
        check("add_alu_a", bus.o_alu_operand_a, 32'd5);
        cyc();
        check("add_valid", bus.o_rsp0_valid, 1'b1);
        check("add_data", bus.o_rsp0_data, 32'd12);
        check("add_zero", bus.o_rsp0_zero, 1'b0);
        bus.i_req0_op = 4'd1; bus.i_req0_a = 32'h1234; bus.i_req0_b = 32'h1234;
        cyc();
        check("sub_data", bus.o_rsp0_data, 32'd0);
        check("sub_zero", bus.o_rsp0_zero, 1'b1);

        // requester 1 alone: 3-1
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b1; bus.i_req1_op = 4'd1; bus.i_req1_a = 32'd3; bus.i_req1_b = 32'd1;
        cyc();
        check("r1_sub_data", bus.o_rsp1_data, 32'd2);

        // contention: both valid for 10 cycles; req0 walks even ops, req1 odd ops
        o0 = 0; o1 = 1;
        bus.i_req0_valid = 1'b1;
        bus.i_req0_op = OW'(o0); bus.i_req0_a = $urandom; bus.i_req0_b = $urandom;
        bus.i_req1_op = OW'(o1); bus.i_req1_a = $urandom; bus.i_req1_b = $urandom;
        for (int i = 0; i < 10; i++) begin
            #1;
            g0 = bus.o_req0_ready;
            check("cont_ready0", g0, (i % 2) == 0);
            cyc();
            if (g0) begin
                o0 += 2;
                bus.i_req0_op = OW'(o0); bus.i_req0_a = $urandom; bus.i_req0_b = $urandom;
            end else begin
                o1 += 2;
                bus.i_req1_op = OW'(o1); bus.i_req1_a = $urandom; bus.i_req1_b = $urandom;
            end
        end
        check("cont_cnt0", bus.o_gnt0_cnt, 4'd8);
        check("cont_cnt1", bus.o_gnt1_cnt, 4'd6);

        // backpressure on slot 1: req0 takes every cycle
        bus.i_rsp1_ready = 1'b0;
        bus.i_req1_op = 4'd0; bus.i_req1_a = 32'd100; bus.i_req1_b = 32'd23;
        bus.i_req0_op = 4'd0; bus.i_req0_a = 32'd1;   bus.i_req0_b = 32'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready1", bus.o_req1_ready, 1'b0);
            check("bp_ready0", bus.o_req0_ready, 1'b1);
            cyc();
            check("bp_rsp1_held", bus.o_rsp1_valid, 1'b1);
        end
        bus.i_rsp1_ready = 1'b1;
        #1;
        check("bp_release_ready1", bus.o_req1_ready, 1'b1);
        cyc();
        check("bp_reload_valid", bus.o_rsp1_valid, 1'b1);
        check("bp_reload_data", bus.o_rsp1_data, 32'd123);
        check("bp_cnt0", bus.o_gnt0_cnt, 4'd11);
        check("bp_cnt1", bus.o_gnt1_cnt, 4'd7);

        // illegal op on requester 1
        bus.i_req0_valid = 1'b0;
        bus.i_req1_op = 4'b1100; bus.i_req1_a = 32'd55; bus.i_req1_b = 32'd66;
        #1;
        check("ill_ready1", bus.o_req1_ready, 1'b1);
        check("ill_alu_op", bus.o_alu_op, 4'd0);
        check("ill_alu_a", bus.o_alu_operand_a, 32'd0);
        cyc();
        check("ill_err", bus.o_rsp1_err, 1'b1);
        check("ill_data", bus.o_rsp1_data, 32'd0);
        check("ill_cnt1", bus.o_gnt1_cnt, 4'd8);

        // mid-stream reset with rsp0 pending and a request in the reset cycle
        bus.i_req1_valid = 1'b0;
        bus.i_req0_valid = 1'b1; bus.i_req0_op = 4'd0; bus.i_req0_a = 32'd2; bus.i_req0_b = 32'd3;
        cyc();
        check("mid_rsp0_data", bus.o_rsp0_data, 32'd5);
        bus.i_rsp0_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_ready0", bus.o_req0_ready, 1'b0);
        cyc();
        check("mid_rsp0_valid", bus.o_rsp0_valid, 1'b0);
        check("mid_cnt0", bus.o_gnt0_cnt, 4'd0);

        // saturation: 20 grants to req0 with a 4-bit counter
        rst = 1'b0;
        bus.i_rsp0_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.i_req0_a = i; bus.i_req0_b = 32'd1;
            cyc();
        end
        check("sat_cnt0", bus.o_gnt0_cnt, 4'd15);
        cyc();
        cyc();
        check("sat_cnt0_hold", bus.o_gnt0_cnt, 4'd15);

        bus.i_req0_valid = 1'b0;
        cyc();
        @(negedge i_clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // absolute runtime bound
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
